// File: rtl/replacer_cnt_sched.sv
// Shares the count-token FIFO between two producers, one frame at a time, with round-robin grant.
// Grant lands one cycle after valid. A write follows each accepted token by one cycle, and cnt_afull gates req_ready combinationally.
module replacer_cnt_sched #(
    parameter int BT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic [1:0]      req_valid,
    input  logic [7:0]      req_cnt0,
    input  logic [7:0]      req_cnt1,
    input  logic [1:0]      req_last,
    input  logic [1:0]      req_sign,
    output logic [1:0]      req_ready,
    input  logic            cnt_afull,
    output logic [7:0]      cnt_out,
    output logic            cnt_wr,
    output logic            last_sign_out,
    output logic [1:0]      grant,
    output logic            busy,
    output logic            frame_done,
    output logic [BT_W-1:0] bit_total,
    output logic            err_sat
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state_q, state_d;
    logic            gnt_idx_q, gnt_idx_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic            sign_q, sign_d;
    logic            err_sat_q, err_sat_d;
    logic            cnt_wr_q, cnt_wr_d;
    logic            frame_done_q, frame_done_d;
    logic [7:0]      cnt_out_q, cnt_out_d;
    logic [BT_W-1:0] bit_total_q, bit_total_d;

    logic            winner;
    logic            xfer;
    logic [7:0]      tok_g;
    logic [7:0]      tok_bits;
    logic [BT_W:0]   sum_ext;

    always_comb begin
        winner   = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
        tok_g    = gnt_idx_q ? req_cnt1 : req_cnt0;
        // An extend flag counts as one extra payload bit on top of the run length.
        tok_bits = {1'b0, tok_g[6:0]} + {7'b0, tok_g[7]};
        sum_ext  = {1'b0, bit_total_q} + (BT_W+1)'(tok_bits);

        req_ready = 2'b00;
        if (state_q == LOCK && clk_en && !cnt_afull) begin
            req_ready[gnt_idx_q] = 1'b1;
        end
        xfer = req_valid[gnt_idx_q] & req_ready[gnt_idx_q];
    end

    always_comb begin
        state_d      = state_q;
        gnt_idx_d    = gnt_idx_q;
        rr_ptr_d     = rr_ptr_q;
        sign_d       = sign_q;
        err_sat_d    = err_sat_q;
        cnt_out_d    = cnt_out_q;
        bit_total_d  = bit_total_q;
        cnt_wr_d     = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d     = LOCK;
                    gnt_idx_d   = winner;
                    sign_d      = req_sign[winner];
                    bit_total_d = '0;
                end
            end
            LOCK: begin
                if (xfer) begin
                    cnt_out_d = tok_g;
                    cnt_wr_d  = 1'b1;
                    if (sum_ext[BT_W]) begin
                        bit_total_d = '1;
                        err_sat_d   = 1'b1;
                    end else begin
                        bit_total_d = sum_ext[BT_W-1:0];
                    end
                    if (req_last[gnt_idx_q]) begin
                        state_d      = IDLE;
                        rr_ptr_d     = ~gnt_idx_q;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            gnt_idx_q    <= 1'b0;
            rr_ptr_q     <= 1'b0;
            sign_q       <= 1'b0;
            err_sat_q    <= 1'b0;
            cnt_wr_q     <= 1'b0;
            frame_done_q <= 1'b0;
            cnt_out_q    <= 8'h00;
            bit_total_q  <= '0;
        end else if (clk_en) begin
            state_q      <= state_d;
            gnt_idx_q    <= gnt_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            sign_q       <= sign_d;
            err_sat_q    <= err_sat_d;
            cnt_wr_q     <= cnt_wr_d;
            frame_done_q <= frame_done_d;
            cnt_out_q    <= cnt_out_d;
            bit_total_q  <= bit_total_d;
        end
    end

    // Strobes are frozen along with the state while clk_en is low; masking them
    // keeps a pending write from repeating and lets it drain once enabled.
    assign cnt_wr        = cnt_wr_q & clk_en;
    assign frame_done    = frame_done_q & clk_en;
    assign cnt_out       = cnt_out_q;
    assign busy          = (state_q == LOCK);
    assign grant         = busy ? (gnt_idx_q ? 2'b10 : 2'b01) : 2'b00;
    assign last_sign_out = sign_q;
    assign bit_total     = bit_total_q;
    assign err_sat       = err_sat_q;

endmodule

// File: tb/tb_replacer_cnt_sched.sv
// Bench for replacer_cnt_sched: a directed vector table, hand-written corner sequences,
// and randomized frames scored against a token/frame-level reference model.
module tb_replacer_cnt_sched;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic [1:0]  req_valid;
    logic [7:0]  req_cnt0;
    logic [7:0]  req_cnt1;
    logic [1:0]  req_last;
    logic [1:0]  req_sign;
    logic [1:0]  req_ready;
    logic        cnt_afull;
    logic [7:0]  cnt_out;
    logic        cnt_wr;
    logic        last_sign_out;
    logic [1:0]  grant;
    logic        busy;
    logic        frame_done;
    logic [15:0] bit_total;
    logic        err_sat;

    replacer_cnt_sched #(.BT_W(16)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid), .req_cnt0(req_cnt0), .req_cnt1(req_cnt1),
        .req_last(req_last), .req_sign(req_sign), .req_ready(req_ready),
        .cnt_afull(cnt_afull), .cnt_out(cnt_out), .cnt_wr(cnt_wr),
        .last_sign_out(last_sign_out), .grant(grant), .busy(busy),
        .frame_done(frame_done), .bit_total(bit_total), .err_sat(err_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state: pending per-requester frames, expected writes, expected frame totals.
    logic [7:0] tq[2][$];
    bit         lq[2][$];
    bit         sq[2][$];
    logic [7:0] wq[$];
    int         fq[$];
    int         owners[$];
    int         starts[$];
    bit         exp_err;
    int         cyc_now;

    typedef struct {
        logic       v0;
        logic [7:0] c0;
        logic       l0;
        logic       s0;
        logic       af;
        logic       en;
        logic [1:0] e_rdy;
        logic [1:0] e_gnt;
        logic       e_wr;
        logic [7:0] e_out;
        logic       e_fd;
        logic [15:0] e_bt;
        logic       e_sign;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(input logic v0, input logic [7:0] c0, input logic l0, input logic s0,
                                input logic af, input logic en, input logic [1:0] e_rdy,
                                input logic [1:0] e_gnt, input logic e_wr, input logic [7:0] e_out,
                                input logic e_fd, input logic [15:0] e_bt, input logic e_sign);
        vec_t v;
        v.v0 = v0; v.c0 = c0; v.l0 = l0; v.s0 = s0; v.af = af; v.en = en;
        v.e_rdy = e_rdy; v.e_gnt = e_gnt; v.e_wr = e_wr; v.e_out = e_out;
        v.e_fd = e_fd; v.e_bt = e_bt; v.e_sign = e_sign;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = 2'b00; req_cnt0 = 8'h00; req_cnt1 = 8'h00;
        req_last = 2'b00; req_sign = 2'b00; cnt_afull = 1'b0; clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_err = 1'b0;
        wq.delete(); fq.delete();
        for (int r = 0; r < 2; r++) begin
            tq[r].delete(); lq[r].delete(); sq[r].delete();
        end
    endtask

    task automatic add_frame(input int r, input int len, input bit sgn, input int fixed);
        for (int k = 0; k < len; k++) begin
            tq[r].push_back(fixed < 0 ? 8'($urandom_range(255)) : 8'(fixed));
            lq[r].push_back(k == len - 1);
            sq[r].push_back(sgn);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cnt_wr"}, 32'(cnt_wr), 0);
        chk({tag, "_cnt_out"}, 32'(cnt_out), 0);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_last_sign"}, 32'(last_sign_out), 0);
        chk({tag, "_bit_total"}, 32'(bit_total), 0);
        chk({tag, "_err_sat"}, 32'(err_sat), 0);
    endtask

    // Drives the queued frames and scores what the DUT writes against the model.
    task automatic run_traffic(input int p_valid, input int p_afull, input int p_en, input int budget);
        int         sum;
        int         cur_owner;
        int         left;
        logic [1:0] v;
        logic [7:0] t;
        bit         lst;
        sum = 0; cur_owner = -1; cyc_now = 0;
        owners.delete(); starts.delete();
        left = tq[0].size() + tq[1].size() + wq.size() + fq.size();
        while (cyc_now < budget && left != 0) begin
            for (int r = 0; r < 2; r++)
                v[r] = (tq[r].size() != 0) && (int'($urandom_range(99)) < p_valid);
            req_valid = v;
            req_cnt0  = tq[0].size() != 0 ? tq[0][0] : 8'h00;
            req_cnt1  = tq[1].size() != 0 ? tq[1][0] : 8'h00;
            req_last  = {tq[1].size() != 0 && lq[1][0], tq[0].size() != 0 && lq[0][0]};
            req_sign  = {tq[1].size() != 0 && sq[1][0], tq[0].size() != 0 && sq[0][0]};
            cnt_afull = int'($urandom_range(99)) < p_afull;
            clk_en    = int'($urandom_range(99)) < p_en;
            @(negedge clk);
            if (cnt_wr) begin
                if (wq.size() == 0) chk("spurious_wr", 32'(cnt_wr), 0);
                else chk("cnt_out", 32'(cnt_out), 32'(wq.pop_front()));
            end
            if (frame_done) begin
                if (fq.size() == 0) chk("spurious_frame_done", 32'(frame_done), 0);
                else chk("frame_bit_total", 32'(bit_total), 32'(fq.pop_front()));
            end
            if (!clk_en) chk("wr_while_disabled", 32'(cnt_wr), 0);
            if (cnt_afull) chk("ready_under_afull", 32'(req_ready), 0);
            chk("ready_not_granted", 32'(req_ready & ~grant), 0);
            chk("busy_vs_grant", 32'(busy), 32'(grant != 2'b00));
            for (int r = 0; r < 2; r++) begin
                if (req_valid[r] && req_ready[r]) begin
                    chk("grant_owner", 32'(grant), 32'(1 << r));
                    chk("last_sign", 32'(last_sign_out), 32'(sq[r][0]));
                    if (cur_owner < 0) begin
                        cur_owner = r;
                        owners.push_back(r);
                        starts.push_back(cyc_now);
                    end else begin
                        chk("frame_contiguous", 32'(r), 32'(cur_owner));
                    end
                    t = tq[r].pop_front();
                    lst = lq[r].pop_front();
                    void'(sq[r].pop_front());
                    wq.push_back(t);
                    sum += int'(t[6:0]) + int'(t[7]);
                    if (lst) begin
                        fq.push_back(sum > 65535 ? 65535 : sum);
                        if (sum > 65535) exp_err = 1'b1;
                        sum = 0;
                        cur_owner = -1;
                    end
                end
            end
            next_cycle();
            cyc_now++;
            left = tq[0].size() + tq[1].size() + wq.size() + fq.size();
        end
        chk("traffic_drained", 32'(left), 0);
        chk("err_sat", 32'(err_sat), 32'(exp_err));
        req_valid = 2'b00; cnt_afull = 1'b0; clk_en = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, actual running required done");
        $fatal(1);
    end

    initial begin
        // Directed table: one 3-token frame, then an almost-full stall, zero token and clk_en gap.
        vt[0]  = mk(1, 8'h85, 0, 1, 0, 1, 2'b00, 2'b00, 0, 8'h00, 0, 16'd0,  0);
        vt[1]  = mk(1, 8'h85, 0, 1, 0, 1, 2'b01, 2'b01, 0, 8'h00, 0, 16'd0,  1);
        vt[2]  = mk(1, 8'h03, 0, 1, 0, 1, 2'b01, 2'b01, 1, 8'h85, 0, 16'd6,  1);
        vt[3]  = mk(1, 8'h07, 1, 1, 0, 1, 2'b01, 2'b01, 1, 8'h03, 0, 16'd9,  1);
        vt[4]  = mk(0, 8'h00, 0, 0, 0, 1, 2'b00, 2'b00, 1, 8'h07, 1, 16'd16, 1);
        vt[5]  = mk(0, 8'h00, 0, 0, 0, 1, 2'b00, 2'b00, 0, 8'h07, 0, 16'd16, 1);
        vt[6]  = mk(1, 8'h00, 0, 0, 0, 1, 2'b00, 2'b00, 0, 8'h07, 0, 16'd16, 1);
        vt[7]  = mk(1, 8'h00, 0, 0, 1, 1, 2'b00, 2'b01, 0, 8'h07, 0, 16'd0,  0);
        vt[8]  = mk(1, 8'h00, 0, 0, 1, 1, 2'b00, 2'b01, 0, 8'h07, 0, 16'd0,  0);
        vt[9]  = mk(1, 8'h00, 0, 0, 1, 1, 2'b00, 2'b01, 0, 8'h07, 0, 16'd0,  0);
        vt[10] = mk(1, 8'h00, 0, 0, 0, 1, 2'b01, 2'b01, 0, 8'h07, 0, 16'd0,  0);
        vt[11] = mk(1, 8'h02, 0, 0, 0, 1, 2'b01, 2'b01, 1, 8'h00, 0, 16'd0,  0);
        vt[12] = mk(1, 8'h80, 1, 0, 0, 0, 2'b00, 2'b01, 0, 8'h02, 0, 16'd2,  0);
        vt[13] = mk(1, 8'h80, 1, 0, 0, 0, 2'b00, 2'b01, 0, 8'h02, 0, 16'd2,  0);
        vt[14] = mk(1, 8'h80, 1, 0, 0, 1, 2'b01, 2'b01, 1, 8'h02, 0, 16'd2,  0);
        vt[15] = mk(0, 8'h00, 0, 0, 0, 1, 2'b00, 2'b00, 1, 8'h80, 1, 16'd3,  0);
        vt[16] = mk(0, 8'h00, 0, 0, 0, 1, 2'b00, 2'b00, 0, 8'h80, 0, 16'd3,  0);

        do_reset();
        @(negedge clk);
        chk_reset_outputs("reset");
        next_cycle();

        for (int i = 0; i < 17; i++) begin
            req_valid = {1'b0, vt[i].v0};
            req_cnt0  = vt[i].c0;
            req_cnt1  = 8'h00;
            req_last  = {1'b0, vt[i].l0};
            req_sign  = {1'b0, vt[i].s0};
            cnt_afull = vt[i].af;
            clk_en    = vt[i].en;
            @(negedge clk);
            chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vt[i].e_rdy));
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vt[i].e_gnt));
            chk($sformatf("vec%0d_cnt_wr", i), 32'(cnt_wr), 32'(vt[i].e_wr));
            chk($sformatf("vec%0d_cnt_out", i), 32'(cnt_out), 32'(vt[i].e_out));
            chk($sformatf("vec%0d_frame_done", i), 32'(frame_done), 32'(vt[i].e_fd));
            chk($sformatf("vec%0d_bit_total", i), 32'(bit_total), 32'(vt[i].e_bt));
            chk($sformatf("vec%0d_last_sign", i), 32'(last_sign_out), 32'(vt[i].e_sign));
            next_cycle();
        end

        // Both requesters always valid with 2-token frames: strict alternation, one idle bubble.
        do_reset();
        add_frame(0, 2, 1, -1); add_frame(0, 2, 1, -1);
        add_frame(1, 2, 0, -1); add_frame(1, 2, 0, -1);
        run_traffic(100, 0, 100, 200);
        chk("alt_frames", 32'(owners.size()), 4);
        foreach (owners[k]) chk($sformatf("alt_owner%0d", k), 32'(owners[k]), 32'(k % 2));
        for (int k = 1; k < starts.size(); k++)
            chk($sformatf("alt_gap%0d", k), 32'(starts[k] - starts[k-1]), 3);

        // 600 maximal run-length tokens in one frame overflow the 16-bit total.
        add_frame(0, 600, 1, 8'h7F);
        run_traffic(100, 0, 100, 2000);
        chk("sat_err_sticky", 32'(err_sat), 1);

        // Random traffic with backpressure and enable gaps; err_sat must stay set.
        for (int f = 0; f < 40; f++) begin
            add_frame(0, int'($urandom_range(6, 1)), bit'($urandom_range(1)), -1);
            add_frame(1, int'($urandom_range(6, 1)), bit'($urandom_range(1)), -1);
        end
        run_traffic(70, 25, 85, 6000);

        // Reset in the middle of requester 1's frame; round-robin pointer must restart at 0.
        do_reset();
        add_frame(0, 2, 0, -1);
        run_traffic(100, 0, 100, 100);
        req_valid = 2'b10; req_sign = 2'b10; req_last = 2'b00; req_cnt1 = 8'h40;
        @(negedge clk);
        chk("mid_idle_grant", 32'(grant), 0);
        next_cycle();
        @(negedge clk);
        chk("mid_grant_rr", 32'(grant), 32'(2'b10));
        chk("mid_ready", 32'(req_ready), 32'(2'b10));
        chk("mid_sign", 32'(last_sign_out), 1);
        next_cycle();
        req_cnt1 = 8'h41;
        @(negedge clk);
        chk("mid_bit_total", 32'(bit_total), 64);
        next_cycle();
        rst = 1'b0; req_cnt1 = 8'h42;
        @(negedge clk);
        chk("mid_rst_frame_done", 32'(frame_done), 0);
        next_cycle();
        rst = 1'b1; req_valid = 2'b11; req_cnt0 = 8'h55; req_sign = 2'b00;
        @(negedge clk);
        chk_reset_outputs("mid_rst");
        next_cycle();
        @(negedge clk);
        chk("mid_rst_rr_grant", 32'(grant), 32'(2'b01));
        next_cycle();
        req_valid = 2'b00;
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
